// File: rtl/grpci2_mst_pkg.sv
// Shared types for the PCI master bridge command scheduling path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package grpci2_mst_pkg;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } sched_state_e;

  // AXI response codes carried on wresp/rresp
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/grpci2_seg_len_calc.sv
// Segment sizer: beats = min(remaining, cacheline cap, beats to next boundary).
// Latency: purely combinational.
// Backpressure: none, stateless.
module grpci2_seg_len_calc #(
  parameter int MAX_BURST = 16,
  parameter int BOUNDARY  = 1024
) (
  input  logic [8:0]  rem,
  input  logic [7:0]  cacheline_size,
  input  logic [31:0] addr,
  output logic [8:0]  beats
);

  localparam logic [8:0]  MAX_B = 9'(MAX_BURST);
  localparam logic [31:0] BND   = 32'(BOUNDARY);

  logic [8:0]  cap;
  logic [8:0]  tob;
  logic [8:0]  rem_cap;
  logic [31:0] tob_full;

  // Cap from cacheline (0 means no cacheline limit), beats to boundary, then three-way min
  always_comb begin
    cap = MAX_B;
    if (cacheline_size != 8'd0 && {1'b0, cacheline_size} < MAX_B) begin
      cap = {1'b0, cacheline_size};
    end
    tob_full = (BND - (addr & (BND - 32'd1))) >> 2;
    tob      = (tob_full > 32'd511) ? 9'd511 : tob_full[8:0];
    rem_cap  = (rem < cap) ? rem : cap;
    beats    = (rem_cap < tob) ? rem_cap : tob;
  end

endmodule

// File: rtl/grpci2_mst_cmd_sched.sv
// Round-robin scheduler of write/read commands into capped, boundary-safe AHB segments.
// Latency: cmd ready 1 cycle after valid seen idle; seg_valid next cycle; resp 1 cycle after last seg_done.
// Backpressure: one command in flight; seg_valid held until seg_ready, resp held until its ready.
module grpci2_mst_cmd_sched
  import grpci2_mst_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int BOUNDARY  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cacheline_size,
  input  logic [3:0]  wcmd_id,
  input  logic [7:0]  wcmd_len,
  input  logic [63:0] wcmd_addr,
  input  logic        wcmd_valid,
  output logic        wcmd_ready,
  input  logic [3:0]  rcmd_id,
  input  logic [7:0]  rcmd_len,
  input  logic [63:0] rcmd_addr,
  input  logic        rcmd_valid,
  output logic        rcmd_ready,
  output logic [3:0]  wresp_id,
  output logic [7:0]  wresp_len,
  output logic [1:0]  wresp_err,
  output logic        wresp_valid,
  input  logic        wresp_ready,
  output logic [3:0]  rresp_id,
  output logic [7:0]  rresp_len,
  output logic [1:0]  rresp_err,
  output logic        rresp_valid,
  input  logic        rresp_ready,
  output logic        seg_write,
  output logic [31:0] seg_addr,
  output logic [7:0]  seg_len,
  output logic        seg_first,
  output logic        seg_last,
  output logic [7:0]  seg_beat_base,
  output logic        seg_valid,
  input  logic        seg_ready,
  input  logic        seg_done,
  input  logic [1:0]  seg_err
);

  sched_state_e state_q, state_d;

  logic        rr_rd_q,  rr_rd_d;   // 1: read has priority on the next tie
  logic        dir_wr_q, dir_wr_d;  // direction of the command in flight
  logic [3:0]  id_q,     id_d;
  logic [7:0]  len_q,    len_d;
  logic [31:0] addr_q,   addr_d;
  logic [8:0]  rem_q,    rem_d;
  logic [8:0]  beats_q,  beats_d;
  logic [7:0]  base_q,   base_d;
  logic        first_q,  first_d;
  logic [1:0]  err_q,    err_d;

  logic        grant_w;
  logic        grant_r;
  logic [63:0] win_addr;
  logic        addr_bad;
  logic        seg_is_last;
  logic        resp_hs;
  logic [8:0]  calc_beats;

  // Arbitration: the rr pointer only matters when both sides request
  assign grant_w     = (state_q == ST_ARB) && wcmd_valid && (!rcmd_valid || !rr_rd_q);
  assign grant_r     = (state_q == ST_ARB) && rcmd_valid && (!wcmd_valid ||  rr_rd_q);
  assign win_addr    = grant_w ? wcmd_addr : rcmd_addr;
  assign addr_bad    = (win_addr[63:32] != 32'd0) || (win_addr[1:0] != 2'b00);
  assign seg_is_last = (beats_q == rem_q);
  assign resp_hs     = (state_q == ST_RESP) && (dir_wr_q ? wresp_ready : rresp_ready);

  // Sizer sees the values the segment will start from, so its result is frozen on ISSUE entry
  grpci2_seg_len_calc #(
    .MAX_BURST (MAX_BURST),
    .BOUNDARY  (BOUNDARY)
  ) u_seg_len_calc (
    .rem            (rem_d),
    .cacheline_size (cacheline_size),
    .addr           (addr_d),
    .beats          (calc_beats)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (wcmd_valid || rcmd_valid) state_d = ST_ARB;
      ST_ARB: begin
        if (grant_w || grant_r) state_d = addr_bad ? ST_RESP : ST_ISSUE;
        else                    state_d = ST_IDLE;
      end
      ST_ISSUE: if (seg_ready) state_d = ST_WAIT;
      ST_WAIT:  if (seg_done)  state_d = seg_is_last ? ST_RESP : ST_ISSUE;
      ST_RESP:  if (resp_hs)   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Command context: latch at grant, advance per completed segment, clear error on response
  always_comb begin
    rr_rd_d  = rr_rd_q;
    dir_wr_d = dir_wr_q;
    id_d     = id_q;
    len_d    = len_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    base_d   = base_q;
    first_d  = first_q;
    err_d    = err_q;
    case (state_q)
      ST_ARB: begin
        if (grant_w || grant_r) begin
          rr_rd_d  = grant_w;
          dir_wr_d = grant_w;
          id_d     = grant_w ? wcmd_id  : rcmd_id;
          len_d    = grant_w ? wcmd_len : rcmd_len;
          addr_d   = win_addr[31:0];
          rem_d    = {1'b0, len_d} + 9'd1;
          base_d   = 8'd0;
          first_d  = 1'b1;
          err_d    = addr_bad ? RESP_SLVERR : RESP_OKAY;
        end
      end
      ST_WAIT: begin
        if (seg_done) begin
          err_d   = err_q | ((seg_err != 2'b00) ? RESP_SLVERR : RESP_OKAY);
          addr_d  = addr_q + {21'd0, beats_q, 2'b00};
          rem_d   = rem_q - beats_q;
          base_d  = base_q + beats_q[7:0];
          first_d = 1'b0;
        end
      end
      ST_RESP: begin
        if (resp_hs) err_d = RESP_OKAY;
      end
      default: ;
    endcase
  end

  // Segment size is captured only when a segment starts, keeping fields stable while issued
  assign beats_d = (state_d == ST_ISSUE && state_q != ST_ISSUE) ? calc_beats : beats_q;

  // Command context registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_rd_q  <= 1'b0;
      dir_wr_q <= 1'b0;
      id_q     <= 4'd0;
      len_q    <= 8'd0;
      addr_q   <= 32'd0;
      rem_q    <= 9'd0;
      beats_q  <= 9'd0;
      base_q   <= 8'd0;
      first_q  <= 1'b0;
      err_q    <= RESP_OKAY;
    end else begin
      rr_rd_q  <= rr_rd_d;
      dir_wr_q <= dir_wr_d;
      id_q     <= id_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      beats_q  <= beats_d;
      base_q   <= base_d;
      first_q  <= first_d;
      err_q    <= err_d;
    end
  end

  // Outputs: handshakes decoded from state, payloads straight from the context registers
  always_comb begin
    wcmd_ready    = grant_w;
    rcmd_ready    = grant_r;
    seg_valid     = (state_q == ST_ISSUE);
    wresp_valid   = (state_q == ST_RESP) &&  dir_wr_q;
    rresp_valid   = (state_q == ST_RESP) && !dir_wr_q;
    seg_write     = dir_wr_q;
    seg_addr      = addr_q;
    seg_len       = beats_q[7:0] - 8'd1;
    seg_first     = first_q;
    seg_last      = seg_is_last;
    seg_beat_base = base_q;
    wresp_id      = id_q;
    wresp_len     = len_q;
    wresp_err     = err_q;
    rresp_id      = id_q;
    rresp_len     = len_q;
    rresp_err     = err_q;
  end

endmodule

// File: tb/tb_grpci2_mst_cmd_sched.sv
// Directed bench for the master command scheduler with a small engine responder.
// Latency: checks grant, first-segment and response cycle positions.
// Backpressure: engine and response sinks always ready; waits are cycle-bounded.
module tb_grpci2_mst_cmd_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cacheline_size;
  logic [3:0]  wcmd_id, rcmd_id;
  logic [7:0]  wcmd_len, rcmd_len;
  logic [63:0] wcmd_addr, rcmd_addr;
  logic        wcmd_valid, wcmd_ready, rcmd_valid, rcmd_ready;
  logic [3:0]  wresp_id, rresp_id;
  logic [7:0]  wresp_len, rresp_len;
  logic [1:0]  wresp_err, rresp_err;
  logic        wresp_valid, wresp_ready, rresp_valid, rresp_ready;
  logic        seg_write, seg_first, seg_last, seg_valid, seg_ready, seg_done;
  logic [31:0] seg_addr;
  logic [7:0]  seg_len, seg_beat_base;
  logic [1:0]  seg_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] s_addr  [8];
  logic [7:0]  s_len   [8];
  logic [7:0]  s_base  [8];
  logic        s_first [8];
  logic        s_last  [8];
  logic        s_wr    [8];
  int          s_wait  [8];
  logic [1:0]  errs    [8];
  int          n_seg;

  logic gw, gr;
  int   lat;

  always #5 clk = ~clk;

  grpci2_mst_cmd_sched dut (
    .clk            (clk),
    .rst            (rst),
    .cacheline_size (cacheline_size),
    .wcmd_id        (wcmd_id),
    .wcmd_len       (wcmd_len),
    .wcmd_addr      (wcmd_addr),
    .wcmd_valid     (wcmd_valid),
    .wcmd_ready     (wcmd_ready),
    .rcmd_id        (rcmd_id),
    .rcmd_len       (rcmd_len),
    .rcmd_addr      (rcmd_addr),
    .rcmd_valid     (rcmd_valid),
    .rcmd_ready     (rcmd_ready),
    .wresp_id       (wresp_id),
    .wresp_len      (wresp_len),
    .wresp_err      (wresp_err),
    .wresp_valid    (wresp_valid),
    .wresp_ready    (wresp_ready),
    .rresp_id       (rresp_id),
    .rresp_len      (rresp_len),
    .rresp_err      (rresp_err),
    .rresp_valid    (rresp_valid),
    .rresp_ready    (rresp_ready),
    .seg_write      (seg_write),
    .seg_addr       (seg_addr),
    .seg_len        (seg_len),
    .seg_first      (seg_first),
    .seg_last       (seg_last),
    .seg_beat_base  (seg_beat_base),
    .seg_valid      (seg_valid),
    .seg_ready      (seg_ready),
    .seg_done       (seg_done),
    .seg_err        (seg_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts and ends just after a rising edge; drops the granted valid after its handshake edge
  task automatic wait_grant(output logic ogw, output logic ogr, output int olat);
    int k;
    k = 0;
    ogw = 1'b0;
    ogr = 1'b0;
    while (k < 20) begin
      @(negedge clk);
      if (wcmd_ready || rcmd_ready) break;
      @(posedge clk); #1;
      k++;
    end
    olat = k;
    if (k < 20) begin
      ogw = wcmd_ready;
      ogr = rcmd_ready;
      @(posedge clk); #1;
      if (ogw) wcmd_valid = 1'b0;
      if (ogr) rcmd_valid = 1'b0;
    end
  endtask

  // Engine responder: accepts each segment, pulses seg_done with errs[i], stops after seg_last
  task automatic serve();
    int k;
    n_seg = 0;
    for (int i = 0; i < 8; i++) begin
      k = 0;
      while (k < 20) begin
        @(negedge clk);
        if (seg_valid) break;
        @(posedge clk); #1;
        k++;
      end
      s_wait[i] = k;
      if (k == 20) begin
        check("seg_valid_timeout", seg_valid, 1);
        @(posedge clk); #1;
        return;
      end
      s_addr[i]  = seg_addr;
      s_len[i]   = seg_len;
      s_base[i]  = seg_beat_base;
      s_first[i] = seg_first;
      s_last[i]  = seg_last;
      s_wr[i]    = seg_write;
      @(posedge clk); #1;
      seg_done = 1'b1;
      seg_err  = errs[i];
      @(negedge clk);
      check("seg_valid_in_wait", seg_valid, 0);
      @(posedge clk); #1;
      seg_done = 1'b0;
      seg_err  = 2'b00;
      n_seg = i + 1;
      if (s_last[i]) break;
    end
  endtask

  // Expects the response in the current cycle, then lets it handshake
  task automatic check_resp(input string tag, input logic w, input logic [3:0] id,
                            input logic [7:0] len, input logic [1:0] err);
    @(negedge clk);
    check({tag, "_seg_vld"}, seg_valid, 0);
    if (w) begin
      check({tag, "_wresp_vld"}, wresp_valid, 1);
      check({tag, "_rresp_vld"}, rresp_valid, 0);
      check({tag, "_id"},  wresp_id,  id);
      check({tag, "_len"}, wresp_len, len);
      check({tag, "_err"}, wresp_err, err);
    end else begin
      check({tag, "_rresp_vld"}, rresp_valid, 1);
      check({tag, "_wresp_vld"}, wresp_valid, 0);
      check({tag, "_id"},  rresp_id,  id);
      check({tag, "_len"}, rresp_len, len);
      check({tag, "_err"}, rresp_err, err);
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_errs();
    for (int i = 0; i < 8; i++) errs[i] = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cacheline_size = 8'd0;
    wcmd_id = 4'd0; wcmd_len = 8'd0; wcmd_addr = 64'd0; wcmd_valid = 1'b0;
    rcmd_id = 4'd0; rcmd_len = 8'd0; rcmd_addr = 64'd0; rcmd_valid = 1'b0;
    wresp_ready = 1'b1; rresp_ready = 1'b1;
    seg_ready = 1'b1; seg_done = 1'b0; seg_err = 2'b00;
    clear_errs();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_seg_vld",   seg_valid,   0);
    check("rst_wresp_vld", wresp_valid, 0);
    check("rst_rresp_vld", rresp_valid, 0);
    check("rst_wcmd_rdy",  wcmd_ready,  0);
    check("rst_rcmd_rdy",  rcmd_ready,  0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single write segment
    cacheline_size = 8'd8;
    wcmd_id = 4'd3; wcmd_len = 8'd7; wcmd_addr = 64'h1000; wcmd_valid = 1'b1;
    wait_grant(gw, gr, lat);
    check("t1_gw", gw, 1);
    check("t1_lat", lat, 1);
    serve();
    check("t1_nseg", n_seg, 1);
    check("t1_wait", s_wait[0], 0);
    check("t1_addr", s_addr[0], 32'h1000);
    check("t1_len", s_len[0], 7);
    check("t1_first", s_first[0], 1);
    check("t1_last", s_last[0], 1);
    check("t1_base", s_base[0], 0);
    check("t1_wr", s_wr[0], 1);
    check_resp("t1", 1'b1, 4'd3, 8'd7, 2'b00);

    // 2: read crossing the 1 KB boundary
    cacheline_size = 8'd16;
    rcmd_id = 4'd5; rcmd_len = 8'd15; rcmd_addr = 64'h3F8; rcmd_valid = 1'b1;
    wait_grant(gw, gr, lat);
    check("t2_gr", gr, 1);
    check("t2_lat", lat, 1);
    serve();
    check("t2_nseg", n_seg, 2);
    check("t2_addr0", s_addr[0], 32'h3F8);
    check("t2_len0", s_len[0], 1);
    check("t2_base0", s_base[0], 0);
    check("t2_first0", s_first[0], 1);
    check("t2_last0", s_last[0], 0);
    check("t2_wr0", s_wr[0], 0);
    check("t2_addr1", s_addr[1], 32'h400);
    check("t2_len1", s_len[1], 13);
    check("t2_base1", s_base[1], 2);
    check("t2_first1", s_first[1], 0);
    check("t2_last1", s_last[1], 1);
    check("t2_wait1", s_wait[1], 0);
    check_resp("t2", 1'b0, 4'd5, 8'd15, 2'b00);

    // 3: simultaneous requests, twice -> W, R, W, R
    for (int r = 0; r < 2; r++) begin
      wcmd_id = 4'd1; wcmd_len = 8'd3; wcmd_addr = 64'h2000; wcmd_valid = 1'b1;
      rcmd_id = 4'd2; rcmd_len = 8'd1; rcmd_addr = 64'h3000; rcmd_valid = 1'b1;
      for (int g = 0; g < 2; g++) begin
        wait_grant(gw, gr, lat);
        check("t3_gw", gw, (g == 0));
        check("t3_gr", gr, (g == 1));
        check("t3_lat", lat, 1);
        serve();
        check("t3_nseg", n_seg, 1);
        if (g == 0) check_resp("t3w", 1'b1, 4'd1, 8'd3, 2'b00);
        else        check_resp("t3r", 1'b0, 4'd2, 8'd1, 2'b00);
      end
    end

    // 4: address above 4 GB -> immediate error response, no segment
    wcmd_id = 4'd7; wcmd_len = 8'd3; wcmd_addr = 64'h0000_0100_0000_1000; wcmd_valid = 1'b1;
    wait_grant(gw, gr, lat);
    check("t4_gw", gw, 1);
    check_resp("t4", 1'b1, 4'd7, 8'd3, 2'b10);

    // 4b: misaligned read address -> error response
    rcmd_id = 4'd6; rcmd_len = 8'd0; rcmd_addr = 64'h1002; rcmd_valid = 1'b1;
    wait_grant(gw, gr, lat);
    check("t4b_gr", gr, 1);
    check_resp("t4b", 1'b0, 4'd6, 8'd0, 2'b10);

    // 5: cacheline 0, error on first of two segments
    cacheline_size = 8'd0;
    clear_errs();
    errs[0] = 2'b10;
    wcmd_id = 4'd9; wcmd_len = 8'd31; wcmd_addr = 64'h0; wcmd_valid = 1'b1;
    wait_grant(gw, gr, lat);
    check("t5_gw", gw, 1);
    serve();
    check("t5_nseg", n_seg, 2);
    check("t5_len0", s_len[0], 15);
    check("t5_last0", s_last[0], 0);
    check("t5_addr1", s_addr[1], 32'h40);
    check("t5_len1", s_len[1], 15);
    check("t5_base1", s_base[1], 16);
    check("t5_last1", s_last[1], 1);
    check_resp("t5", 1'b1, 4'd9, 8'd31, 2'b10);

    // 5b: cacheline above MAX_BURST is capped; error accumulator starts clean
    cacheline_size = 8'd32;
    clear_errs();
    wcmd_id = 4'd10; wcmd_len = 8'd19; wcmd_addr = 64'h100; wcmd_valid = 1'b1;
    wait_grant(gw, gr, lat);
    serve();
    check("t5b_nseg", n_seg, 2);
    check("t5b_len0", s_len[0], 15);
    check("t5b_addr1", s_addr[1], 32'h140);
    check("t5b_len1", s_len[1], 3);
    check("t5b_base1", s_base[1], 16);
    check_resp("t5b", 1'b1, 4'd10, 8'd19, 2'b00);

    // 6: reset while waiting for seg_done
    cacheline_size = 8'd4;
    rcmd_id = 4'd2; rcmd_len = 8'd15; rcmd_addr = 64'h0; rcmd_valid = 1'b1;
    wait_grant(gw, gr, lat);
    @(negedge clk);
    check("t6_issue_vld", seg_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_seg_vld",   seg_valid,   0);
    check("t6_wresp_vld", wresp_valid, 0);
    check("t6_rresp_vld", rresp_valid, 0);
    check("t6_rcmd_rdy",  rcmd_ready,  0);
    @(posedge clk); #1;
    rst = 1'b0;
    seg_done = 1'b1;
    seg_err  = 2'b10;
    @(posedge clk); #1;
    seg_done = 1'b0;
    seg_err  = 2'b00;
    @(negedge clk);
    check("t6_idle_rresp", rresp_valid, 0);
    check("t6_idle_seg", seg_valid, 0);
    @(posedge clk); #1;
    rcmd_id = 4'd4; rcmd_len = 8'd3; rcmd_addr = 64'h800; rcmd_valid = 1'b1;
    wait_grant(gw, gr, lat);
    check("t6_gr", gr, 1);
    check("t6_lat", lat, 1);
    serve();
    check("t6_nseg", n_seg, 1);
    check("t6_addr", s_addr[0], 32'h800);
    check("t6_len", s_len[0], 3);
    check("t6_first", s_first[0], 1);
    check("t6_last", s_last[0], 1);
    check_resp("t6", 1'b0, 4'd4, 8'd3, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
